// File: rtl/imm_extend_pipe.sv
// Immediate generator: extracts/extends the immediate of a 32-bit instruction
// and queues the result in a 2-entry skid FIFO with valid/ready on both sides.
module imm_extend_pipe #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [2:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic              illegal
);

  localparam int unsigned EXT_W = 64;
  localparam int unsigned CNT_W = 2;

  logic [EXT_W-1:0]  ext_c;
  logic              ill_c;
  logic [DATA_W-1:0] new_imm_c;
  logic              push_c;
  logic              pop_c;
  logic              unused_c;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] head_imm_q, head_imm_d;
  logic              head_ill_q, head_ill_d;
  logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
  logic              skid_ill_q, skid_ill_d;

  // Field extraction and extension at full 64-bit width, truncated afterwards.
  always_comb begin
    ext_c = '0;
    ill_c = 1'b0;
    unique case (mode)
      3'd0: ext_c = EXT_W'(instr[21:10]);
      3'd1: ext_c = {{(EXT_W-9){instr[20]}}, instr[20:12]};
      3'd2: ext_c = {{(EXT_W-26){instr[25]}}, instr[25:0]} << BR_SHIFT;
      3'd3: ext_c = {{(EXT_W-19){instr[23]}}, instr[23:5]} << BR_SHIFT;
      3'd4: ext_c = EXT_W'(instr[20:5]) << {instr[22:21], 4'b0000};
      3'd5: ext_c = EXT_W'(instr[15:10]);
      default: ill_c = 1'b1;
    endcase
  end

  assign new_imm_c = ext_c[DATA_W-1:0];
  assign unused_c  = ^{instr[31:26], ext_c};

  assign push_c = in_valid && in_ready_q;
  assign pop_c  = out_valid_q && out_ready;

  // Occupancy and entry movement; head entry drives the outputs directly.
  always_comb begin
    count_d    = count_q;
    head_imm_d = head_imm_q;
    head_ill_d = head_ill_q;
    skid_imm_d = skid_imm_q;
    skid_ill_d = skid_ill_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({push_c, pop_c})
        2'b10: begin
          if (count_q == CNT_W'(0)) begin
            head_imm_d = new_imm_c;
            head_ill_d = ill_c;
            count_d    = CNT_W'(1);
          end else begin
            skid_imm_d = new_imm_c;
            skid_ill_d = ill_c;
            count_d    = CNT_W'(2);
          end
        end
        2'b01: begin
          if (count_q == CNT_W'(2)) begin
            head_imm_d = skid_imm_q;
            head_ill_d = skid_ill_q;
            count_d    = CNT_W'(1);
          end else begin
            count_d = '0;
          end
        end
        2'b11: begin
          head_imm_d = new_imm_c;
          head_ill_d = ill_c;
        end
        default: ;
      endcase
    end
    in_ready_d  = (count_d != CNT_W'(2));
    out_valid_d = (count_d != CNT_W'(0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_imm_q  <= '0;
      head_ill_q  <= 1'b0;
      skid_imm_q  <= '0;
      skid_ill_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_imm_q  <= head_imm_d;
      head_ill_q  <= head_ill_d;
      skid_imm_q  <= skid_imm_d;
      skid_ill_q  <= skid_ill_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign imm       = head_imm_q;
  assign illegal   = head_ill_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: 64- and 32-bit instances share stimulus and are
// scoreboarded against an arithmetic immediate model and a FIFO queue.
module tb_imm_extend_pipe;

  localparam int unsigned BR_SHIFT = 2;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [2:0]  mode;
  logic        in_ready, out_valid, illegal;
  logic [63:0] imm;
  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;

  imm_extend_pipe #(.DATA_W(64), .BR_SHIFT(BR_SHIFT)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .illegal(illegal));

  imm_extend_pipe #(.DATA_W(32), .BR_SHIFT(BR_SHIFT)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .mode(mode), .out_valid(out_valid32), .out_ready(out_ready),
    .imm(imm32), .illegal(illegal32));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ill;
    logic [63:0] val;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   n_emit = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Immediate computed with integer arithmetic from the format rules.
  function automatic ent_t model(input logic [31:0] ins, input logic [2:0] m);
    longint f, v;
    ent_t   e;
    f = longint'({32'd0, ins});
    v = 0;
    e.ill = 1'b0;
    case (m)
      3'd0: v = (f >> 10) & 'hFFF;
      3'd1: begin v = (f >> 12) & 'h1FF; if (v >= 256) v = v - 512; end
      3'd2: begin
        v = f & 'h3FFFFFF;
        if (v >= 'h2000000) v = v - 'h4000000;
        v = v * (longint'(1) << BR_SHIFT);
      end
      3'd3: begin
        v = (f >> 5) & 'h7FFFF;
        if (v >= 'h40000) v = v - 'h80000;
        v = v * (longint'(1) << BR_SHIFT);
      end
      3'd4: v = ((f >> 5) & 'hFFFF) * (longint'(1) << (16 * ((f >> 21) & 3)));
      3'd5: v = (f >> 10) & 'h3F;
      default: e.ill = 1'b1;
    endcase
    e.val = 64'(v);
    return e;
  endfunction

  // One clock: model the handshake, advance, then compare against the queue.
  task automatic cyc(output bit acc);
    bit   emt;
    ent_t nw;
    acc = in_valid && in_ready;
    emt = out_valid && out_ready;
    nw  = model(instr, mode);
    @(posedge clk); #1;
    if (flush) q.delete();
    else begin
      if (emt) begin void'(q.pop_front()); n_emit++; end
      if (acc) begin q.push_back(nw); n_acc++; end
    end
    chk("out_valid",   64'(out_valid),   64'(q.size() != 0));
    chk("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
    chk("in_ready",    64'(in_ready),    64'(q.size() < 2));
    chk("in_ready32",  64'(in_ready32),  64'(q.size() < 2));
    if (q.size() != 0) begin
      chk("imm",       imm,              q[0].val);
      chk("illegal",   64'(illegal),     64'(q[0].ill));
      chk("imm32",     64'(imm32),       64'(q[0].val[31:0]));
      chk("illegal32", 64'(illegal32),   64'(q[0].ill));
    end
  endtask

  task automatic tick();
    bit a;
    cyc(a);
  endtask

  task automatic dir(input string tag, input logic [31:0] ins, input logic [2:0] m,
                     input logic [63:0] exp, input logic ill, input logic [31:0] exp32);
    in_valid = 1'b1; instr = ins; mode = m; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk(tag, imm, exp);
    chk({tag, "_ill"}, 64'(illegal), 64'(ill));
    chk({tag, "_32"}, 64'(imm32), 64'(exp32));
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ov"},   64'(out_valid),  64'd0);
    chk({tag, "_ir"},   64'(in_ready),   64'd0);
    chk({tag, "_imm"},  imm,             64'd0);
    chk({tag, "_ill"},  64'(illegal),    64'd0);
    chk({tag, "_ov32"}, 64'(out_valid32), 64'd0);
    chk({tag, "_imm32"}, 64'(imm32),     64'd0);
  endtask

  initial begin
    logic [31:0] bw[3];
    logic [2:0]  bm[3];
    int w;
    bit a;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; mode = '0;
    #12;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Directed format checks with hand-computed values.
    dir("m1_neg",   32'h001F_0000, 3'd1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 32'hFFFF_FFF0);
    dir("m2_neg",   32'h03FF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
    dir("m3_pos",   32'h0000_0020, 3'd3, 64'h4,                   1'b0, 32'h4);
    dir("m0_max",   32'h003F_FC00, 3'd0, 64'hFFF,                 1'b0, 32'hFFF);
    dir("m4_sh3",   32'h0077_DDE0, 3'd4, 64'hBEEF_0000_0000_0000, 1'b0, 32'h0);
    dir("m4_sh1",   32'h0037_DDE0, 3'd4, 64'h0000_0000_BEEF_0000, 1'b0, 32'hBEEF_0000);
    dir("m5_max",   32'hFFFF_FC00, 3'd5, 64'h3F,                  1'b0, 32'h3F);
    dir("m6_ill",   32'hFFFF_FFFF, 3'd6, 64'h0,                   1'b1, 32'h0);
    dir("m7_ill",   32'h1234_5678, 3'd7, 64'h0,                   1'b1, 32'h0);

    // Back-pressure: three words offered, only two fit.
    for (int i = 0; i < 3; i++) begin bw[i] = $urandom; bm[i] = 3'($urandom_range(0, 5)); end
    out_ready = 1'b0; in_valid = 1'b1; w = 0;
    for (int i = 0; i < 7 && w < 3; i++) begin
      instr = bw[w]; mode = bm[w];
      cyc(a);
      if (a) w++;
    end
    chk("bp_accepted", 64'(w), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && w < 3; i++) begin
      instr = bw[w]; mode = bm[w];
      cyc(a);
      if (a) w++;
    end
    chk("bp_third", 64'(w), 64'd3);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Streaming: one word per cycle, occupancy stays at one.
    in_valid = 1'b1; out_ready = 1'b1; w = 0;
    instr = $urandom; mode = 3'($urandom_range(0, 7));
    for (int i = 0; i < 60 && w < 20; i++) begin
      cyc(a);
      if (a) begin
        w++;
        chk("stream_occ", 64'(q.size()), 64'd1);
        instr = $urandom; mode = 3'($urandom_range(0, 7));
      end
    end
    chk("stream_words", 64'(w), 64'd20);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stream_no_drop", 64'(n_emit), 64'(n_acc));

    // Flush at full occupancy with a competing in_valid.
    out_ready = 1'b0; in_valid = 1'b1; w = 0;
    for (int i = 0; i < 6 && w < 2; i++) begin
      instr = $urandom; mode = 3'($urandom_range(0, 5));
      cyc(a);
      if (a) w++;
    end
    chk("fl_fill", 64'(w), 64'd2);
    flush = 1'b1; instr = 32'h00FF_FFFF; mode = 3'd2;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_ov", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) tick();

    // Flush at occupancy one beating both a same-cycle accept and emit.
    in_valid = 1'b1; instr = $urandom; mode = 3'd0;
    tick();
    out_ready = 1'b1; flush = 1'b1; instr = $urandom; mode = 3'd1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_ov", 64'(out_valid), 64'd0);
    tick();

    // Random traffic with an asynchronous reset pulse in the middle.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 24) == 0);
      instr     = $urandom;
      mode      = 3'($urandom_range(0, 7));
      if (i == 150) begin
        #2 reset = 1'b0;
        #1 chk_reset_outputs("arst");
        q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        tick();
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_ov", 64'(out_valid), 64'd0);
      end else begin
        tick();
      end
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
